timer_counter_core: RTL and testbench

TIMER_COUNTER_CORE -- requirements
Module: timer_counter_core

---
 rtl/timer_counter_core_if.sv | 23 ++
 rtl/timer_counter_core.sv | 76 +++++++
 tb/tb_timer_counter_core.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/timer_counter_core_if.sv
// Control/status bundle for timer_counter_core.
//   master: drives en, load, up_dn, cks, tdr_i; observes cnt_o, ovf_o, udf_o
//   slave : the timer core itself
interface timer_counter_core_if;
    logic       en;
    logic       load;
    logic       up_dn;
    logic [1:0] cks;
    logic [7:0] tdr_i;
    logic [7:0] cnt_o;
    logic       ovf_o;
    logic       udf_o;

    modport master (
        output en, load, up_dn, cks, tdr_i,
        input  cnt_o, ovf_o, udf_o
    );

    modport slave (
        input  en, load, up_dn, cks, tdr_i,
        output cnt_o, ovf_o, udf_o
    );
endinterface

// File: rtl/timer_counter_core.sv
// 8-bit up/down timer with a 4-bit prescaler and one-cycle overflow/underflow pulses.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - timer_counter_core_if.slave:
//           en, load, up_dn, cks[1:0], tdr_i[7:0] in; cnt_o[7:0], ovf_o, udf_o out (registered)
module timer_counter_core (
    input  logic                  clk,
    input  logic                  rst_n,
    timer_counter_core_if.slave   bus
);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned DIV_W = 4;

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             udf_q;
    logic             run_c;
    logic             div_full_c;
    logic             tick_c;

    // Prescaler runs only while counting is enabled and no load is requested.
    assign run_c = bus.en & ~bus.load;

    // Prescaler terminal count for the selected divide ratio (div_cnt[cks:0] all ones).
    always_comb begin
        div_full_c = 1'b0;
        case (bus.cks)
            2'b00:   div_full_c = div_cnt[0];
            2'b01:   div_full_c = &div_cnt[1:0];
            2'b10:   div_full_c = &div_cnt[2:0];
            default: div_full_c = &div_cnt[3:0];
        endcase
    end

    assign tick_c = run_c & div_full_c;

    // Prescaler: free-running wrap while enabled, cleared otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (run_c) begin
            div_cnt <= div_cnt + DIV_W'(1);
        end else begin
            div_cnt <= '0;
        end
    end

    // Counter and wrap pulses; load has priority over tick, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
            if (bus.load) begin
                cnt_q <= bus.tdr_i;
            end else if (tick_c) begin
                if (bus.up_dn) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    udf_q <= (cnt_q == '0);
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    ovf_q <= (cnt_q == '1);
                end
            end
        end
    end

    assign bus.cnt_o = cnt_q;
    assign bus.ovf_o = ovf_q;
    assign bus.udf_o = udf_q;
endmodule

// File: tb/tb_timer_counter_core.sv
// Directed bench for timer_counter_core: wrap pulses, prescaler ratios, load priority,
// enable freeze, select change mid-count and asynchronous reset.
module tb_timer_counter_core;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    timer_counter_core_if bus ();

    timer_counter_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp_cnt,
                       input logic exp_ovf, input logic exp_udf);
        vectors++;
        assert (bus.cnt_o === exp_cnt) else begin
            miscompares++;
            $error("FAIL %s cnt_o observed=%h expected=%h", tag, bus.cnt_o, exp_cnt);
        end
        vectors++;
        assert (bus.ovf_o === exp_ovf) else begin
            miscompares++;
            $error("FAIL %s ovf_o observed=%b expected=%b", tag, bus.ovf_o, exp_ovf);
        end
        vectors++;
        assert (bus.udf_o === exp_udf) else begin
            miscompares++;
            $error("FAIL %s udf_o observed=%b expected=%b", tag, bus.udf_o, exp_udf);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        bus.en      = 1'b0;
        bus.load    = 1'b0;
        bus.up_dn   = 1'b0;
        bus.cks     = 2'b00;
        bus.tdr_i   = 8'h00;

        // Power-up reset
        #1 rst_n = 1'b0;
        #1 chk("reset", 8'h00, 1'b0, 1'b0);
        step(1);
        rst_n = 1'b1;
        step(1);
        chk("idle_after_reset", 8'h00, 1'b0, 1'b0);

        // Load FD, count up with clk/2 through FF -> 00
        bus.tdr_i = 8'hFD;
        bus.load  = 1'b1;
        step(1);
        bus.load  = 1'b0;
        chk("load_fd", 8'hFD, 1'b0, 1'b0);
        bus.en    = 1'b1;
        bus.up_dn = 1'b0;
        bus.cks   = 2'b00;
        step(1); chk("up_e1", 8'hFD, 1'b0, 1'b0);
        step(1); chk("up_e2", 8'hFE, 1'b0, 1'b0);
        step(1); chk("up_e3", 8'hFE, 1'b0, 1'b0);
        step(1); chk("up_e4", 8'hFF, 1'b0, 1'b0);
        step(1); chk("up_e5", 8'hFF, 1'b0, 1'b0);
        step(1); chk("up_e6_ovf", 8'h00, 1'b1, 1'b0);
        step(1); chk("up_e7_ovf_clr", 8'h00, 1'b0, 1'b0);

        // Load 02, count down with clk/4 through 00 -> FF
        bus.tdr_i = 8'h02;
        bus.load  = 1'b1;
        bus.up_dn = 1'b1;
        bus.cks   = 2'b01;
        step(1);
        chk("load_02", 8'h02, 1'b0, 1'b0);
        bus.load  = 1'b0;
        step(3);  chk("dn_e3", 8'h02, 1'b0, 1'b0);
        step(1);  chk("dn_e4", 8'h01, 1'b0, 1'b0);
        step(4);  chk("dn_e8", 8'h00, 1'b0, 1'b0);
        step(3);  chk("dn_e11", 8'h00, 1'b0, 1'b0);
        step(1);  chk("dn_e12_udf", 8'hFF, 1'b0, 1'b1);
        step(1);  chk("dn_e13_udf_clr", 8'hFF, 1'b0, 1'b0);

        // Reset between edges while running at 10
        bus.tdr_i = 8'h0F;
        bus.load  = 1'b1;
        bus.up_dn = 1'b0;
        bus.cks   = 2'b00;
        step(1);
        bus.load  = 1'b0;
        step(2);
        chk("run_10", 8'h10, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 8'h00, 1'b0, 1'b0);
        step(1);
        chk("reset_held", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1); chk("post_rst_e1", 8'h00, 1'b0, 1'b0);
        step(1); chk("post_rst_e2", 8'h01, 1'b0, 1'b0);

        // en and load together: load wins, no tick; tdr_i change afterwards ignored
        bus.tdr_i = 8'h55;
        bus.load  = 1'b1;
        step(1); chk("load55_c1", 8'h55, 1'b0, 1'b0);
        step(1); chk("load55_c2", 8'h55, 1'b0, 1'b0);
        step(1); chk("load55_c3", 8'h55, 1'b0, 1'b0);
        bus.load  = 1'b0;
        bus.tdr_i = 8'hAA;
        step(1); chk("after_load_e1", 8'h55, 1'b0, 1'b0);
        step(1); chk("after_load_e2", 8'h56, 1'b0, 1'b0);

        // clk/16, then freeze with en=0 for 20 cycles
        bus.tdr_i = 8'h20;
        bus.load  = 1'b1;
        step(1);
        bus.load  = 1'b0;
        bus.cks   = 2'b11;
        step(15); chk("div16_e15", 8'h20, 1'b0, 1'b0);
        step(1);  chk("div16_e16", 8'h21, 1'b0, 1'b0);
        step(5);
        bus.en = 1'b0;
        step(20); chk("frozen", 8'h21, 1'b0, 1'b0);
        bus.en = 1'b1;
        step(15); chk("reen_e15", 8'h21, 1'b0, 1'b0);
        step(1);  chk("reen_e16", 8'h22, 1'b0, 1'b0);

        // Prescaler now 0; advance to 5 then switch to clk/2
        step(5);  chk("div_at_5", 8'h22, 1'b0, 1'b0);
        bus.cks = 2'b00;
        step(1);  chk("cks_sw_e1", 8'h23, 1'b0, 1'b0);
        step(1);  chk("cks_sw_e2", 8'h23, 1'b0, 1'b0);
        step(1);  chk("cks_sw_e3", 8'h24, 1'b0, 1'b0);

        // clk/8 down from 00 to FF, then reverse direction back through FF -> 00
        bus.tdr_i = 8'h00;
        bus.load  = 1'b1;
        bus.up_dn = 1'b1;
        bus.cks   = 2'b10;
        step(1);
        bus.load  = 1'b0;
        step(7);  chk("div8_dn_e7", 8'h00, 1'b0, 1'b0);
        step(1);  chk("div8_dn_e8_udf", 8'hFF, 1'b0, 1'b1);
        bus.up_dn = 1'b0;
        step(1);  chk("dir_change", 8'hFF, 1'b0, 1'b0);
        step(6);  chk("div8_up_e15", 8'hFF, 1'b0, 1'b0);
        step(1);  chk("div8_up_e16_ovf", 8'h00, 1'b1, 1'b0);
        step(1);  chk("div8_up_e17", 8'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
